// File: rtl/bw_io_impctl_dtl_avgctl.sv
// Averaging up/down controller for the impedance-control loop: integrates the
// comparator over WIN sample strobes, decides INC/DEC/HOLD, steps the code on the next update.
// Latency: decision on the deciding sample edge, code step on the following update edge; no backpressure.
//
// Ports:
//   clk, reset          : single clock, synchronous active-high reset
//   sclk_en, updclk_en  : single-cycle sample / update strobes
//   avgcntr_rst         : clears the averaging window and any pending step
//   bypass, bypass_code : force the code to bypass_code on each update strobe
//   comp_out            : pad comparator result, 1 votes up, 0 votes down
//   code, code_upd      : registered impedance code and its one-cycle change pulse
//   lock                : loop has held for LOCK_N consecutive windows
module bw_io_impctl_dtl_avgctl #(
  parameter int                 CODE_W   = 8,
  parameter int                 WIN      = 16,
  parameter int                 THRESH   = 4,
  parameter logic [CODE_W-1:0]  CODE_RST = CODE_W'('h40),
  parameter int                 LOCK_N   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk_en,
  input  logic              updclk_en,
  input  logic              avgcntr_rst,
  input  logic              bypass,
  input  logic [CODE_W-1:0] bypass_code,
  input  logic              comp_out,
  output logic [CODE_W-1:0] code,
  output logic              code_upd,
  output logic              lock
);

  localparam int SW = $clog2(WIN);
  // Two extra bits: one for sign, one so +WIN/-WIN cannot wrap.
  localparam int AW = SW + 2;

  localparam logic signed [AW-1:0] P_ONE = AW'(1);
  localparam logic signed [AW-1:0] N_ONE = AW'(-1);
  localparam logic signed [AW-1:0] THR_P = AW'(THRESH);
  localparam logic signed [AW-1:0] THR_N = AW'(-THRESH);
  localparam logic [SW-1:0]        LAST  = SW'(WIN - 1);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_PEND  = 1'b1;

  localparam logic [1:0] PEND_NONE = 2'd0;
  localparam logic [1:0] PEND_INC  = 2'd1;
  localparam logic [1:0] PEND_DEC  = 2'd2;

  logic [0:0]            state;
  logic signed [AW-1:0]  acc;
  logic [SW-1:0]         scnt;
  logic [1:0]            pend;
  logic [3:0]            hcnt;

  logic signed [AW-1:0]  acc_nxt;
  logic [3:0]            hcnt_inc;
  logic                  hold_lock;
  logic [CODE_W-1:0]     code_up;
  logic [CODE_W-1:0]     code_dn;

  always_comb begin
    acc_nxt   = acc + (comp_out ? P_ONE : N_ONE);
    hcnt_inc  = (hcnt == 4'hF) ? 4'hF : hcnt + 4'd1;
    // Compare hcnt+1 in 5 bits so 15+1 does not wrap to 0.
    hold_lock = (({1'b0, hcnt} + 5'd1) >= 5'(LOCK_N));
    code_up   = (code == {CODE_W{1'b1}}) ? code : code + CODE_W'(1);
    code_dn   = (code == {CODE_W{1'b0}}) ? code : code - CODE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_ACCUM;
      acc      <= '0;
      scnt     <= '0;
      pend     <= PEND_NONE;
      hcnt     <= '0;
      code     <= CODE_RST;
      code_upd <= 1'b0;
      lock     <= 1'b0;
    end else begin
      code_upd <= 1'b0;
      if (bypass) begin
        // Loop is frozen at an empty window; only the update strobe matters.
        state <= ST_ACCUM;
        acc   <= '0;
        scnt  <= '0;
        pend  <= PEND_NONE;
        hcnt  <= '0;
        lock  <= 1'b0;
        if (updclk_en) begin
          code     <= bypass_code;
          code_upd <= 1'b1;
        end
      end else if (avgcntr_rst) begin
        // code and lock deliberately keep their values.
        state <= ST_ACCUM;
        acc   <= '0;
        scnt  <= '0;
        pend  <= PEND_NONE;
        hcnt  <= '0;
      end else begin
        case (state)
          ST_ACCUM: begin
            if (sclk_en) begin
              if (scnt == LAST) begin
                acc  <= '0;
                scnt <= '0;
                if (acc_nxt >= THR_P) begin
                  pend  <= PEND_INC;
                  hcnt  <= '0;
                  lock  <= 1'b0;
                  state <= ST_PEND;
                end else if (acc_nxt <= THR_N) begin
                  pend  <= PEND_DEC;
                  hcnt  <= '0;
                  lock  <= 1'b0;
                  state <= ST_PEND;
                end else begin
                  hcnt <= hcnt_inc;
                  if (hold_lock) begin
                    lock <= 1'b1;
                  end
                end
              end else begin
                acc  <= acc_nxt;
                scnt <= scnt + SW'(1);
              end
            end
          end
          ST_PEND: begin
            // Samples arriving while a step is pending are ignored.
            if (updclk_en) begin
              code     <= (pend == PEND_INC) ? code_up : code_dn;
              code_upd <= 1'b1;
              pend     <= PEND_NONE;
              state    <= ST_ACCUM;
            end
          end
          default: begin
            state <= ST_ACCUM;
            pend  <= PEND_NONE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bw_io_impctl_dtl_avgctl.sv
// Self-checking bench for bw_io_impctl_dtl_avgctl: directed scenarios plus a random
// phase, every cycle compared against a vote-counting reference model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_bw_io_impctl_dtl_avgctl;

  localparam int WIN    = 16;
  localparam int THRESH = 4;
  localparam int LOCK_N = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk_en;
  logic       updclk_en;
  logic       avgcntr_rst;
  logic       bypass;
  logic [7:0] bypass_code;
  logic       comp_out;
  logic [7:0] code;
  logic       code_upd;
  logic       lock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: counts votes in the current window; pending step as +1/-1/0.
  int m_code, m_n, m_ones, m_pend, m_holds;
  bit m_lock, m_upd;

  always #5 clk = ~clk;

  bw_io_impctl_dtl_avgctl #(
    .CODE_W(8), .WIN(WIN), .THRESH(THRESH), .CODE_RST(8'h40), .LOCK_N(LOCK_N)
  ) dut (
    .clk(clk), .reset(reset), .sclk_en(sclk_en), .updclk_en(updclk_en),
    .avgcntr_rst(avgcntr_rst), .bypass(bypass), .bypass_code(bypass_code),
    .comp_out(comp_out), .code(code), .code_upd(code_upd), .lock(lock)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit u, input bit a,
                            input bit b, input bit c, input int bc);
    int net;
    m_upd = 1'b0;
    if (r) begin
      m_code = 'h40; m_n = 0; m_ones = 0; m_pend = 0; m_holds = 0; m_lock = 1'b0;
    end else if (b) begin
      m_n = 0; m_ones = 0; m_pend = 0; m_holds = 0; m_lock = 1'b0;
      if (u) begin
        m_code = bc;
        m_upd  = 1'b1;
      end
    end else if (a) begin
      m_n = 0; m_ones = 0; m_pend = 0; m_holds = 0;
    end else if (m_pend != 0) begin
      if (u) begin
        m_code = m_code + m_pend;
        if (m_code > 255) m_code = 255;
        if (m_code < 0)   m_code = 0;
        m_upd  = 1'b1;
        m_pend = 0;
      end
    end else if (s) begin
      m_ones += int'(c);
      m_n++;
      if (m_n == WIN) begin
        net = 2 * m_ones - WIN;
        if (net >= THRESH)       m_pend = 1;
        else if (net <= -THRESH) m_pend = -1;
        m_n = 0;
        m_ones = 0;
        if (m_pend != 0) begin
          m_holds = 0;
          m_lock  = 1'b0;
        end else begin
          m_holds = (m_holds >= 15) ? 15 : m_holds + 1;
          if (m_holds >= LOCK_N) m_lock = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare after it.
  task automatic cyc(input bit s, input bit u, input bit a, input bit b, input bit c,
                     input bit r = 1'b0);
    reset = r; sclk_en = s; updclk_en = u; avgcntr_rst = a; bypass = b; comp_out = c;
    @(posedge clk);
    model_step(r, s, u, a, b, c, int'(bypass_code));
    #1;
    chk("code", 32'(code), 32'(m_code));
    chk("code_upd", 32'(code_upd), 32'(m_upd));
    chk("lock", 32'(lock), 32'(m_lock));
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic upd();
    cyc(0, 1, 0, 0, 0);
  endtask

  // kind: 0 all zeros, 1 all ones, 2 alternating 1/0; idle gaps between samples.
  task automatic window(input int kind, input int nsamp = WIN);
    for (int i = 0; i < nsamp; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      cyc(1, 0, 0, 0, (kind == 2) ? ((i % 2) == 0) : (kind == 1));
    end
  endtask

  initial begin
    int bias;
    reset = 1'b1; sclk_en = 0; updclk_en = 0; avgcntr_rst = 0; bypass = 0;
    comp_out = 0; bypass_code = 8'h00;

    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 1, 1);
    chk("rst_code", 32'(code), 32'h40);
    chk("rst_lock", 32'(lock), 32'h0);

    // Basic step up.
    window(1);
    idle();
    chk("inc_no_early", 32'(code), 32'h40);
    upd();
    chk("inc_code", 32'(code), 32'h41);
    chk("inc_pulse", 32'(code_upd), 32'h1);
    idle();
    chk("inc_pulse_single", 32'(code_upd), 32'h0);

    // Three balanced windows raise lock; an all-zero window clears it and steps down.
    window(2);
    window(2);
    chk("lock_pre", 32'(lock), 32'h0);
    window(2);
    chk("lock_set", 32'(lock), 32'h1);
    upd();
    chk("hold_code", 32'(code), 32'h41);
    window(0);
    chk("lock_clr", 32'(lock), 32'h0);
    upd();
    chk("dec_code", 32'(code), 32'h40);

    // Partial window discarded by avgcntr_rst.
    window(1, 10);
    cyc(0, 0, 1, 0, 0);
    window(0);
    upd();
    chk("arst_partial", 32'(code), 32'h3F);

    // avgcntr_rst while a step is pending cancels it.
    window(1);
    cyc(0, 0, 1, 0, 0);
    upd();
    chk("arst_pend_code", 32'(code), 32'h3F);
    chk("arst_pend_pulse", 32'(code_upd), 32'h0);

    // Sample coinciding with avgcntr_rst is dropped: 15 more samples do not finish the window.
    cyc(1, 0, 1, 0, 1);
    window(1, WIN - 1);
    upd();
    chk("drop_sample", 32'(code), 32'h3F);
    window(1, 1);
    upd();
    chk("drop_then_step", 32'(code), 32'h40);

    // Bypass rising together with the update strobe while INC pending.
    window(1);
    bypass_code = 8'h22;
    cyc(0, 1, 0, 1, 0);
    chk("byp_rise_code", 32'(code), 32'h22);
    idle();
    upd();
    chk("byp_pend_gone", 32'(code), 32'h22);

    // Bypass with two update strobes, then release and step up.
    bypass_code = 8'h22;
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    chk("byp_upd1", 32'(code_upd), 32'h1);
    cyc(1, 0, 0, 1, 1);
    cyc(0, 1, 0, 1, 0);
    chk("byp_upd2", 32'(code_upd), 32'h1);
    chk("byp_lock", 32'(lock), 32'h0);
    idle();
    window(1);
    upd();
    chk("byp_release", 32'(code), 32'h23);

    // Upper saturation, then confirm loop is back in ACCUM by stepping down.
    bypass_code = 8'hFF;
    cyc(0, 1, 0, 1, 0);
    idle();
    window(1);
    upd();
    chk("sat_hi_code", 32'(code), 32'hFF);
    chk("sat_hi_pulse", 32'(code_upd), 32'h1);
    window(0);
    upd();
    chk("sat_hi_resume", 32'(code), 32'hFE);

    // Lower saturation.
    bypass_code = 8'h00;
    cyc(0, 1, 0, 1, 0);
    idle();
    window(0);
    upd();
    chk("sat_lo_code", 32'(code), 32'h00);
    chk("sat_lo_pulse", 32'(code_upd), 32'h1);

    // Random phase with a slowly changing comparator bias.
    bias = 50;
    for (int i = 0; i < 4000; i++) begin
      if ((i % 150) == 0) bias = $urandom_range(0, 100);
      if ((i % 97) == 0) bypass_code = 8'($urandom);
      cyc(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 10),
          ($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 2),
          ($urandom_range(0, 99) < bias));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
